// File: rtl/icache_axi_refill.sv
// icache_axi_refill
// Refill engine between the instruction cache and the AXI read channel.
// Takes one line-read request, issues a single INCR burst, gathers the
// returned beats into a line buffer and hands the full line back to the
// cache with a one-cycle valid pulse. Only one burst is ever in flight.
module icache_axi_refill #(
  parameter logic [3:0] ARID       = 4'd0,
  parameter int         DATA_WIDTH = 32,
  parameter int         BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  // ICache side
  input  logic                          icache_rd_req,
  input  logic [31:0]                   icache_rd_addr,
  output logic                          icache_rd_rdy,
  output logic                          icache_ret_valid,
  output logic [BEATS*DATA_WIDTH-1:0]   icache_ret_data,
  // AXI read address channel
  output logic [3:0]                    arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI read data channel
  input  logic [3:0]                    rid,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam int LINE_W = BEATS * DATA_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_RDATA = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_take_s;
  logic                beat_take_s;
  logic                unused_ok;

  // Response code and in-line offset carry no information for the refill.
  assign unused_ok = ^{rresp, icache_rd_addr[OFF_W-1:0]};

  // A request is taken only when idle; a beat only while collecting and
  // only when it carries our ID (foreign beats are drained but discarded).
  assign req_take_s  = (state_q == S_IDLE) && icache_rd_req;
  assign beat_take_s = (state_q == S_RDATA) && rvalid && (rid == ARID);

  // State register with asynchronous reset back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the refill sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (icache_rd_req) begin
          state_d = S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (arready) begin
          state_d = S_RDATA;
        end else begin
          state_d = S_AR;
        end
      end
      S_RDATA: begin
        // Finish on rlast, or once the last word slot has been filled even
        // if the slave never flags rlast.
        if (beat_take_s && (rlast || (cnt_q == LAST_IDX))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    icache_rd_rdy    = 1'b0;
    arvalid          = 1'b0;
    rready           = 1'b0;
    icache_ret_valid = 1'b0;
    case (state_q)
      S_IDLE:  icache_rd_rdy    = 1'b1;
      S_AR:    arvalid          = 1'b1;
      S_RDATA: rready           = 1'b1;
      S_DONE:  icache_ret_valid = 1'b1;
      default: icache_rd_rdy    = 1'b0;
    endcase
  end

  // Datapath: address latch, line assembly and saturating beat counter.
  always_comb begin
    araddr_d = araddr_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    if (req_take_s) begin
      araddr_d = {icache_rd_addr[31:OFF_W], {OFF_W{1'b0}}};
      line_d   = '0;
      cnt_d    = '0;
    end else if (beat_take_s) begin
      line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
      if (cnt_q != LAST_IDX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers; cleared on reset so an aborted burst leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_q <= 32'd0;
      line_q   <= '0;
      cnt_q    <= '0;
    end else begin
      araddr_q <= araddr_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
    end
  end

  assign icache_ret_data = line_q;
  assign araddr          = araddr_q;
  assign arid            = ARID;
  assign arlen           = 8'(BEATS - 1);
  assign arsize          = 3'($clog2(DATA_WIDTH / 8));
  assign arburst         = 2'b01;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: a transaction-level model predicts every
// handshake output and the assembled line each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_icache_axi_refill;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_rd_req;
  logic [31:0]  icache_rd_addr;
  logic         icache_rd_rdy;
  logic         icache_ret_valid;
  logic [127:0] icache_ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  always #5 clk = ~clk;

  icache_axi_refill dut (
    .clk(clk), .reset(reset),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
    .icache_ret_data(icache_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_ar_open: burst requested, address not yet accepted by the slave
  // m_reading: address accepted, still collecting beats
  // m_handing: the line is being handed to the cache this cycle
  logic         m_ar_open, m_reading, m_handing;
  logic [31:0]  m_addr;
  logic [127:0] m_line;
  int           m_words;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ar_open <= 1'b0;
      m_reading <= 1'b0;
      m_handing <= 1'b0;
      m_addr    <= 32'd0;
      m_line    <= 128'd0;
      m_words   <= 0;
    end else begin
      m_handing <= 1'b0;
      if (!m_ar_open && !m_reading && !m_handing && icache_rd_req) begin
        m_ar_open <= 1'b1;
        m_addr    <= icache_rd_addr & 32'hFFFF_FFF0;
        m_line    <= 128'd0;
        m_words   <= 0;
      end
      if (m_ar_open && arready) begin
        m_ar_open <= 1'b0;
        m_reading <= 1'b1;
      end
      if (m_reading && rvalid && (rid == 4'd0)) begin
        m_line[m_words*32 +: 32] <= rdata;
        if (rlast || (m_words == 3)) begin
          m_reading <= 1'b0;
          m_handing <= 1'b1;
        end else begin
          m_words <= m_words + 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("rd_rdy", icache_rd_rdy, !(m_ar_open || m_reading || m_handing));
    chk("arvalid", arvalid, m_ar_open);
    chk("rready", rready, m_reading);
    chk("ret_valid", icache_ret_valid, m_handing);
    chk("ret_data", icache_ret_data, m_line);
    chk("araddr", araddr, m_addr);
    if (arvalid) begin
      chk("arlen", arlen, 8'd3);
      chk("arsize", arsize, 3'd2);
      chk("arburst", arburst, 2'b01);
      chk("arid", arid, 4'd0);
    end
    if (icache_ret_valid) pulses++;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic req_line(input logic [31:0] a);
    icache_rd_req  = 1'b1;
    icache_rd_addr = a;
    for (int i = 0; i < 50; i++) begin
      if (icache_rd_rdy) begin
        @(posedge clk); #1;
        icache_rd_req = 1'b0;
        chk("arvalid_latency", arvalid, 1'b1);
        return;
      end
      @(posedge clk); #1;
    end
    chk("req_timeout", 1'b0, 1'b1);
    icache_rd_req = 1'b0;
  endtask

  task automatic ar_hs(input int dly, input logic [31:0] exp_a);
    for (int i = 0; i < dly; i++) begin
      chk("ar_hold_valid", arvalid, 1'b1);
      chk("ar_hold_addr", araddr, exp_a);
      chk("ar_hold_rdy", icache_rd_rdy, 1'b0);
      @(posedge clk); #1;
    end
    chk("ar_addr", araddr, exp_a);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("rready_latency", rready, 1'b1);
    chk("arvalid_drop", arvalid, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] id, input logic last, input int gap);
    rvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rvalid = 1'b1; rdata = d; rid = id; rlast = last;
    for (int i = 0; i < 50; i++) begin
      if (rready) begin
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("beat_timeout", 1'b0, 1'b1);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  // Called right after the final beat: line must be out this cycle only.
  task automatic expect_line(input string nm, input logic [127:0] exp);
    chk({nm, "_valid"}, icache_ret_valid, 1'b1);
    chk({nm, "_data"}, icache_ret_data, exp);
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, icache_ret_valid, 1'b0);
    chk({nm, "_hold"}, icache_ret_data, exp);
    chk({nm, "_idle"}, icache_rd_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; icache_rd_req = 1'b0; icache_rd_addr = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
    rlast = 1'b0; rvalid = 1'b0;
    #12;
    chk("rst_rdy", icache_rd_rdy, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_ret_valid", icache_ret_valid, 1'b0);
    chk("rst_ret_data", icache_ret_data, 128'd0);
    chk("rst_araddr", araddr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic refill
    req_line(32'h1FC0_0010);
    ar_hs(0, 32'h1FC0_0010);
    beat(32'h11, 4'd0, 1'b0, 0);
    beat(32'h22, 4'd0, 1'b0, 0);
    beat(32'h33, 4'd0, 1'b0, 0);
    beat(32'h44, 4'd0, 1'b1, 0);
    expect_line("basic", 128'h00000044_00000033_00000022_00000011);

    // Alignment and AR backpressure, one beat flagged SLVERR
    req_line(32'hBFC0_037C);
    ar_hs(5, 32'hBFC0_0370);
    beat(32'hCAFE_0001, 4'd0, 1'b0, 0);
    rresp = 2'b10;
    beat(32'hCAFE_0002, 4'd0, 1'b0, 1);
    rresp = 2'b00;
    beat(32'hCAFE_0003, 4'd0, 1'b0, 0);
    beat(32'hCAFE_0004, 4'd0, 1'b1, 0);
    expect_line("align", 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001);

    // R bubbles plus a foreign-ID beat
    req_line(32'h0000_2468);
    ar_hs(2, 32'h0000_2460);
    beat(32'hA1A1_A1A1, 4'd0, 1'b0, 2);
    beat(32'hBAD0_BAD0, 4'd5, 1'b0, 1);
    beat(32'hA2A2_A2A2, 4'd0, 1'b0, 0);
    beat(32'hA3A3_A3A3, 4'd0, 1'b0, 3);
    beat(32'hA4A4_A4A4, 4'd0, 1'b1, 1);
    expect_line("foreign", 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1);

    // Fourth beat without rlast still completes the line
    req_line(32'h0000_5000);
    ar_hs(0, 32'h0000_5000);
    beat(32'h5, 4'd0, 1'b0, 0);
    beat(32'h6, 4'd0, 1'b0, 0);
    beat(32'h7, 4'd0, 1'b0, 0);
    beat(32'h8, 4'd0, 1'b0, 0);
    expect_line("no_rlast", 128'h00000008_00000007_00000006_00000005);

    // Early rlast on second beat
    req_line(32'h0000_0100);
    ar_hs(1, 32'h0000_0100);
    beat(32'hA, 4'd0, 1'b0, 0);
    beat(32'hB, 4'd0, 1'b1, 0);
    expect_line("early", 128'h00000000_00000000_0000000B_0000000A);

    // Reset after two beats, with the slave still streaming
    req_line(32'h0000_3000);
    ar_hs(0, 32'h0000_3000);
    beat(32'hDEAD_0001, 4'd0, 1'b0, 0);
    beat(32'hDEAD_0002, 4'd0, 1'b0, 0);
    rvalid = 1'b1; rdata = 32'hDEAD_0003; rid = 4'd0;
    #2 reset = 1'b1;
    #1;
    chk("abort_rdy", icache_rd_rdy, 1'b1);
    chk("abort_rready", rready, 1'b0);
    chk("abort_arvalid", arvalid, 1'b0);
    chk("abort_data", icache_ret_data, 128'd0);
    chk("abort_araddr", araddr, 32'd0);
    @(negedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ignored", rready, 1'b0);
    rvalid = 1'b0;
    req_line(32'h0000_4000);
    ar_hs(0, 32'h0000_4000);
    beat(32'h0000_0C01, 4'd0, 1'b0, 0);
    beat(32'h0000_0C02, 4'd0, 1'b0, 0);
    beat(32'h0000_0C03, 4'd0, 1'b0, 0);
    beat(32'h0000_0C04, 4'd0, 1'b1, 0);
    expect_line("fresh", 128'h00000C04_00000C03_00000C02_00000C01);

    // Back-to-back: second request raised while the first line is returned
    req_line(32'h0000_1000);
    ar_hs(0, 32'h0000_1000);
    beat(32'h1, 4'd0, 1'b0, 0);
    beat(32'h2, 4'd0, 1'b0, 0);
    beat(32'h3, 4'd0, 1'b0, 0);
    beat(32'h4, 4'd0, 1'b1, 0);
    chk("b2b_first", icache_ret_data, 128'h00000004_00000003_00000002_00000001);
    chk("b2b_first_valid", icache_ret_valid, 1'b1);
    chk("b2b_busy", icache_rd_rdy, 1'b0);
    req_line(32'h0000_2000);
    ar_hs(0, 32'h0000_2000);
    beat(32'h9, 4'd0, 1'b0, 0);
    beat(32'h10, 4'd0, 1'b1, 0);
    expect_line("b2b_second", 128'h00000000_00000000_00000010_00000009);

    repeat (2) @(posedge clk);
    #1;
    chk("ret_pulses", pulses, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
